// File: rtl/csa_pkg.sv
// csa_pkg: shared state type and column-count helper for the carry-select adder
package csa_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} csa_state_t;
  function automatic int ncol(int width, int col_w);
    return width / col_w;
  endfunction
endpackage

// File: rtl/csa_seq_adder_if.sv
// csa_seq_adder_if: start/busy/done handshake and operand/result bus
interface csa_seq_adder_if #(parameter int WIDTH = 16);
  logic Start;
  logic Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic C_out;
  logic Overflow;
  logic Busy;
  logic Done;
  modport master(output Start, Sub, A, B, input Sum, C_out, Overflow, Busy, Done);
  modport slave(input Start, Sub, A, B, output Sum, C_out, Overflow, Busy, Done);
endinterface

// File: rtl/csa_col_n.sv
// csa_col_n: combinational carry-select column, both carry-in cases precomputed
module csa_col_n #(parameter int COL_W = 4) (
  input  logic [COL_W-1:0] a,
  input  logic [COL_W-1:0] b,
  input  logic             c_in,
  output logic [COL_W-1:0] s,
  output logic             c_out
);
  logic [COL_W:0] r0, r1;
  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + (COL_W+1)'(1);
  assign s = c_in ? r1[COL_W-1:0] : r0[COL_W-1:0];
  assign c_out = r0[COL_W] | (c_in & r1[COL_W]);
endmodule

// File: rtl/csa_seq_adder.sv
// csa_seq_adder: multi-cycle add/sub retiring one carry-select column per clock
module csa_seq_adder import csa_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int COL_W = 4
) (
  input logic Clk,
  input logic Reset,
  csa_seq_adder_if.slave bus
);
  localparam int NCOL = ncol(WIDTH, COL_W);
  localparam int CNT_W = NCOL > 1 ? $clog2(NCOL) : 1;
  csa_state_t state;
  logic [WIDTH-1:0] a_r, b_r, psum, nsum;
  logic [CNT_W-1:0] cnt;
  logic carry, c, last, accept;
  logic [COL_W-1:0] s;
  int idx;
  assign last = cnt == CNT_W'(NCOL - 1);
  assign accept = bus.Start && state != RUN;
  assign bus.Busy = state == RUN;
  assign bus.Done = state == DONE;
  csa_col_n #(.COL_W(COL_W)) u_col (
    .a(a_r[idx +: COL_W]),
    .b(b_r[idx +: COL_W]),
    .c_in(carry),
    .s(s),
    .c_out(c)
  );
  // merge the column being retired into the partial sum
  always_comb begin
    idx = int'(cnt) * COL_W;
    nsum = psum;
    nsum[idx +: COL_W] = s;
  end
  // sequencer: latch operands, walk columns, publish result on DONE entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      psum <= '0;
      carry <= 1'b0;
      cnt <= '0;
      bus.Sum <= '0;
      bus.C_out <= 1'b0;
      bus.Overflow <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      a_r <= bus.A;
      b_r <= bus.Sub ? ~bus.B : bus.B;
      carry <= bus.Sub;
      cnt <= '0;
    end else if (state == RUN) begin
      psum <= nsum;
      carry <= c;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        state <= DONE;
        bus.Sum <= nsum;
        bus.C_out <= c;
        bus.Overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nsum[WIDTH-1] != a_r[WIDTH-1]);
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_csa_seq_adder.sv
// tb_csa_seq_adder: directed checks of csa_seq_adder at three parameter points
module tb_csa_seq_adder;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  csa_seq_adder_if #(.WIDTH(16)) d16 ();
  csa_seq_adder_if #(.WIDTH(8)) d8 ();
  csa_seq_adder_if #(.WIDTH(32)) d32 ();
  csa_seq_adder #(.WIDTH(16), .COL_W(4)) u16 (.Clk(clk), .Reset(rst), .bus(d16));
  csa_seq_adder #(.WIDTH(8), .COL_W(8)) u8 (.Clk(clk), .Reset(rst), .bus(d8));
  csa_seq_adder #(.WIDTH(32), .COL_W(4)) u32 (.Clk(clk), .Reset(rst), .bus(d32));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic sub, output int t0);
    d16.Start = 1'b1; d16.A = a; d16.B = b; d16.Sub = sub;
    t0 = cyc;
    @(negedge clk);
    d16.Start = 1'b0;
  endtask
  task automatic wait16(input int t0, output int lat, output int busy);
    busy = 0;
    for (int i = 0; i < 40 && !d16.Done; i++) begin
      if (d16.Busy) busy++;
      @(negedge clk);
    end
    lat = cyc - t0;
  endtask
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic [15:0] es, input logic ec, input logic eo);
    int t0, lat, busy;
    start16(a, b, sub, t0);
    wait16(t0, lat, busy);
    chk({tag, " latency"}, lat, 5);
    chk({tag, " sum"}, d16.Sum, es);
    chk({tag, " c_out"}, d16.C_out, ec);
    chk({tag, " ovf"}, d16.Overflow, eo);
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [7:0] be;
    logic [8:0] r;
    int t0, lat;
    be = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, be} + 9'(sub);
    d8.Start = 1'b1; d8.A = a; d8.B = b; d8.Sub = sub;
    t0 = cyc;
    @(negedge clk);
    d8.Start = 1'b0;
    for (int i = 0; i < 40 && !d8.Done; i++) @(negedge clk);
    lat = cyc - t0;
    chk("w8 latency", lat, 2);
    chk("w8 sum", d8.Sum, r[7:0]);
    chk("w8 c_out", d8.C_out, r[8]);
    chk("w8 ovf", d8.Overflow, (a[7] == be[7]) && (r[7] != a[7]));
    @(negedge clk);
  endtask
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] be;
    logic [32:0] r;
    int t0, lat;
    be = sub ? ~b : b;
    r = {1'b0, a} + {1'b0, be} + 33'(sub);
    d32.Start = 1'b1; d32.A = a; d32.B = b; d32.Sub = sub;
    t0 = cyc;
    @(negedge clk);
    d32.Start = 1'b0;
    for (int i = 0; i < 40 && !d32.Done; i++) @(negedge clk);
    lat = cyc - t0;
    chk("w32 latency", lat, 9);
    chk("w32 sum", d32.Sum, r[31:0]);
    chk("w32 c_out", d32.C_out, r[32]);
    chk("w32 ovf", d32.Overflow, (a[31] == be[31]) && (r[31] != a[31]));
    @(negedge clk);
  endtask
  initial begin
    int t0, lat, busy, seen;
    d16.Start = 0; d16.Sub = 0; d16.A = 0; d16.B = 0;
    d8.Start = 0; d8.Sub = 0; d8.A = 0; d8.B = 0;
    d32.Start = 0; d32.Sub = 0; d32.A = 0; d32.B = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset sum", d16.Sum, 0);
    chk("reset c_out", d16.C_out, 0);
    chk("reset ovf", d16.Overflow, 0);
    chk("reset busy", d16.Busy, 0);
    chk("reset done", d16.Done, 0);
    start16(16'h0001, 16'h0001, 1'b0, t0);
    wait16(t0, lat, busy);
    chk("add1 busy cycles", busy, 4);
    chk("add1 latency", lat, 5);
    chk("add1 sum", d16.Sum, 16'h0002);
    chk("add1 c_out", d16.C_out, 0);
    chk("add1 ovf", d16.Overflow, 0);
    chk("add1 busy at done", d16.Busy, 0);
    @(negedge clk);
    chk("done pulse width", d16.Done, 0);
    chk("sum held in idle", d16.Sum, 16'h0002);
    op16("carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    op16("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    op16("sub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    @(negedge clk);
    op16("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);
    start16(16'h0001, 16'h0001, 1'b0, t0);
    chk("sum stable in run", d16.Sum, 16'h7FFF);
    d16.Start = 1'b1; d16.A = 16'h1234; d16.B = 16'h4321;
    @(negedge clk);
    d16.Start = 1'b0;
    wait16(t0, lat, busy);
    chk("ignore latency", lat, 5);
    chk("ignore sum", d16.Sum, 16'h0002);
    op16("b2b first", 16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0);
    op16("b2b second", 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0);
    @(negedge clk);
    start16(16'h00FF, 16'h0001, 1'b0, t0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", d16.Busy, 0);
    chk("abort done", d16.Done, 0);
    chk("abort sum", d16.Sum, 0);
    chk("abort c_out", d16.C_out, 0);
    chk("abort ovf", d16.Overflow, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (d16.Done) seen = 1;
    end
    chk("abort no done", seen, 0);
    op8(8'h7F, 8'h01, 1'b0);
    op8(8'h80, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
    op32(32'hFFFFFFFF, 32'h00000001, 1'b0);
    op32(32'h80000000, 32'h00000001, 1'b1);
    for (int i = 0; i < 4; i++) op32($urandom, $urandom, 1'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csa_seq_adder.md
Name: csa_seq_adder

Overview:
- Parametrised, multi-cycle carry-select adder/subtractor for the LC-3 datapath and its test harnesses.
- Splits a WIDTH-bit add into COL_W-bit carry-select columns and retires one column per clock, so wide operands can be added with a small area footprint.
- A Start/Busy/Done handshake lets a controlling FSM launch an operation and collect the result.
- Adds subtraction, signed overflow detection and result holding to the existing 4-bit column.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of COL_W.
- COL_W, 4, bits retired per RUN cycle (carry-select column width).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request a new operation; sampled only in IDLE or DONE.
- Sub  in  1  0 = A+B, 1 = A-B; sampled with Start.
- A  in  WIDTH  first operand; sampled with Start.
- B  in  WIDTH  second operand; sampled with Start.
- Sum  out  WIDTH  result; holds its value until the next Done.
- C_out  out  1  carry out of the MSB. For Sub, 1 means no borrow.
- Overflow  out  1  two's-complement overflow of the last result.
- Busy  out  1  high while in RUN.
- Done  out  1  one-cycle pulse when Sum, C_out and Overflow update.

Behaviour:
- NCOL = WIDTH/COL_W. Internal state: operand registers, Beff = Sub ? ~B : B, running carry, column counter, partial-sum register.
- Reset: state=IDLE; Sum=0; C_out=0; Overflow=0; Busy=0; Done=0; counter=0. Reset takes priority over every other event, including reset in the middle of RUN, which abandons the operation.
- IDLE: Start=1 latches A, B^{Sub}, Sub; carry<=Sub; counter<=0; next state RUN. Start=0 stays in IDLE.
- RUN: Busy=1. Each cycle computes column [counter*COL_W +: COL_W] with the csa_col_n sub-block:
  - both candidate sums are formed (carry-in 0 and carry-in 1), and the running carry selects one;
  - the selected sum is written into the partial-sum register;
  - carry <= selected column carry out;
  - counter increments.
  - After the column with counter=NCOL-1, next state is DONE.
  - Start is ignored while in RUN; there is no queuing.
- DONE: lasts exactly one cycle.
  - Done=1 and Busy=0.
  - Sum, C_out and Overflow load from the internal registers on the entry edge, so they are valid in the same cycle Done=1.
  - Overflow = (A[MSB]==Beff[MSB]) && (Sum[MSB]!=A[MSB]).
  - Start=1 in DONE is accepted back-to-back: same actions as in IDLE, next state RUN.
  - Otherwise next state is IDLE.
- Latency: Start sampled at edge k, so Busy is high for cycles k+1..k+NCOL and Done is high in cycle k+NCOL+1. Throughput is one operation per NCOL+1 cycles.
- Sum, C_out and Overflow change only at DONE entry or on Reset. They are stable during RUN and IDLE.
- Widths: all arithmetic is modulo 2^WIDTH. No sign extension.
- Degenerate case: COL_W=WIDTH gives NCOL=1, so Done appears 2 cycles after Start.

Decomposition:
- Shared package csa_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} csa_state_t;
  - the function ncol(WIDTH, COL_W).
- Sub-module csa_col_n (parameter COL_W): the combinational carry-select column.
  - Two ripple sums, one with carry-in 0 and one with carry-in 1.
  - Selected output s = c_in ? s1 : s0.
  - c_out = c0 | (c_in & c1).
  - Instantiated once in csa_seq_adder and time-multiplexed across columns.

Test Plan:
- Add, WIDTH=16, COL_W=4: Start with A=x0001, B=x0001, Sub=0 -> Busy high 4 cycles, Done in cycle 5, Sum=x0002, C_out=0, Overflow=0.
- Carry and overflow on add:
  - A=xFFFF, B=x0001 -> Sum=x0000, C_out=1, Overflow=0.
  - A=x7FFF, B=x0001 -> Sum=x8000, C_out=0, Overflow=1.
- Subtract:
  - A=x0005, B=x0007, Sub=1 -> Sum=xFFFE, C_out=0, Overflow=0.
  - A=x8000, B=x0001, Sub=1 -> Sum=x7FFF, C_out=1, Overflow=1.
- Handshake:
  - Start pulsed during RUN with different operands -> ignored; the first result is unchanged.
  - Start held high in the DONE cycle -> second op accepted; its Done appears 5 cycles later.
- Reset at RUN cycle 2 -> next cycle state=IDLE, Busy=0, Sum=0, C_out=0, Overflow=0, and no Done pulse.
- Parameter sweep: WIDTH=8, COL_W=8 and WIDTH=32, COL_W=4 with random operands against a reference model -> Done latency of NCOL+1 cycles and exact Sum, C_out and Overflow.
